// File: rtl/sfr_bus_master_pkg.sv
// Shared types for the SFR bus master: FSM state encoding, strobe width
// and the latched request record.
package sfr_bus_pkg;

    localparam int SFR_DATA_W     = 32;
    localparam int SFR_ADDR_W     = 8;
    localparam int SFR_STRB_WIDTH = SFR_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        RSP     = 2'd3
    } sfr_bus_state_e;

    // One accepted request, held for the whole transaction.
    typedef struct packed {
        logic                      we;
        logic [SFR_ADDR_W-1:0]     addr;
        logic [SFR_DATA_W-1:0]     wdata;
        logic [SFR_STRB_WIDTH-1:0] wstrb;
    } sfr_req_t;

endpackage

// File: rtl/sfr_bus_master_if.sv
// Request/response handshake plus the SFR map strobes, bundled as one
// interface. master = the bus master, slave = core + SFR map side.
interface sfr_bus_master_if #(
    parameter int SFR_WIDTH      = 32,
    parameter int SFR_ADDR_WIDTH = 8
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [SFR_ADDR_WIDTH-1:0] req_addr;
    logic [SFR_WIDTH-1:0]      req_wdata;
    logic [SFR_WIDTH/8-1:0]    req_wstrb;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [SFR_WIDTH-1:0]      rsp_rdata;
    logic                      rsp_err;

    logic [SFR_ADDR_WIDTH-1:0] sfr_addr;
    logic                      sfr_ren;
    logic                      sfr_wen;
    logic [SFR_WIDTH-1:0]      sfr_din;
    logic [SFR_WIDTH-1:0]      sfr_dout;
    logic                      sfr_rdonly;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  rsp_ready, sfr_dout, sfr_rdonly,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output sfr_addr, sfr_ren, sfr_wen, sfr_din
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output rsp_ready, sfr_dout, sfr_rdonly,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  sfr_addr, sfr_ren, sfr_wen, sfr_din
    );
endinterface

// File: rtl/sfr_bus_master_rmw_merge.sv
// Byte-lane merge for read-modify-write: lanes with a set strobe take the
// new data, the rest keep the word read back from the map.
module sfr_rmw_merge #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   old_data_i,
    input  logic [WIDTH-1:0]   new_data_i,
    input  logic [WIDTH/8-1:0] wstrb_i,
    output logic [WIDTH-1:0]   merged_o
);
    for (genvar gi = 0; gi < WIDTH / 8; gi++) begin : g_lane
        assign merged_o[gi*8 +: 8] = wstrb_i[gi] ? new_data_i[gi*8 +: 8]
                                                 : old_data_i[gi*8 +: 8];
    end
endmodule

// File: rtl/sfr_bus_master.sv
// SFR bus master: single outstanding read/write to the SFR map, response
// on a valid/ready channel. Optional feature macro: SFR_BUS_RMW_EN enables
// read-modify-write for partial-strobe writes; without it every write is a
// full-word write and wstrb is ignored.
module sfr_bus_master
    import sfr_bus_pkg::*;
#(
    parameter int SFR_WIDTH      = SFR_DATA_W,
    parameter int SFR_ADDR_WIDTH = SFR_ADDR_W,
    parameter int RD_LATENCY     = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             sys_clk_en,
    sfr_bus_master_if.master bus
);
    localparam int               CNT_W    = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY);

    sfr_bus_state_e       state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    sfr_req_t             req_q, req_d;
    logic [SFR_WIDTH-1:0] din_q, din_d;
    logic [SFR_WIDTH-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;

`ifdef SFR_BUS_RMW_EN
    logic [SFR_WIDTH-1:0] merged_data;

    sfr_rmw_merge #(.WIDTH(SFR_WIDTH)) u_merge (
        .old_data_i (bus.sfr_dout),
        .new_data_i (req_q.wdata),
        .wstrb_i    (req_q.wstrb),
        .merged_o   (merged_data)
    );
`else
    // Without RMW the latched strobes, write data copy and direction are never consulted.
    logic unused_req;
    assign unused_req = ^{req_q.we, req_q.wdata, req_q.wstrb};
`endif

    // State and datapath registers; everything clears asynchronously.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath updates; nothing moves while sys_clk_en is low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (sys_clk_en) begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_d.we    = bus.req_we;
                        req_d.addr  = SFR_ADDR_W'(bus.req_addr);
                        req_d.wdata = SFR_DATA_W'(bus.req_wdata);
                        req_d.wstrb = SFR_STRB_WIDTH'(bus.req_wstrb);
                        cnt_d       = '0;
                        rdata_d     = '0;
                        err_d       = 1'b0;
                        if (bus.req_we) begin
                            din_d = bus.req_wdata;
                        end
                        if (!bus.req_we) begin
                            state_d = RD_WAIT;
`ifdef SFR_BUS_RMW_EN
                        end else if (bus.req_wstrb == '0) begin
                            state_d = RSP;
                        end else if (&bus.req_wstrb) begin
                            state_d = WR;
                        end else begin
                            state_d = RD_WAIT;
                        end
`else
                        end else begin
                            state_d = WR;
                        end
`endif
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == CNT_LAST) begin
`ifdef SFR_BUS_RMW_EN
                        if (req_q.we) begin
                            din_d   = merged_data;
                            state_d = WR;
                        end else
`endif
                        begin
                            rdata_d = bus.sfr_dout;
                            state_d = RSP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WR: begin
                    err_d   = bus.sfr_rdonly;
                    state_d = RSP;
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE) && !sys_rst;
    assign bus.rsp_valid = (state_q == RSP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.sfr_addr  = SFR_ADDR_WIDTH'(req_q.addr);
    assign bus.sfr_din   = din_q;
    // Read strobe only in the first RD_WAIT cycle; write strobe suppressed for read-only targets.
    assign bus.sfr_ren   = (state_q == RD_WAIT) && (cnt_q == '0);
    assign bus.sfr_wen   = (state_q == WR) && !bus.sfr_rdonly;

endmodule

// File: tb/tb_sfr_bus_master.sv
// Bench for sfr_bus_master: directed requests, expected responses queued
// into a scoreboard that a separate monitor checks on each handshake.
module tb_sfr_bus_master;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic sys_clk    = 1'b0;
    logic sys_rst    = 1'b1;
    logic sys_clk_en = 1'b1;
    logic map_init   = 1'b1;

    sfr_bus_master_if #(.SFR_WIDTH(32), .SFR_ADDR_WIDTH(8)) bus ();

    sfr_bus_master #(
        .SFR_WIDTH      (32),
        .SFR_ADDR_WIDTH (8),
        .RD_LATENCY     (1)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .sys_clk_en (sys_clk_en),
        .bus        (bus.master)
    );

    always #5 sys_clk = ~sys_clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // SFR map model: one-cycle registered read, write on wen, address 0x30 read-only.
    logic [31:0] mem [256];
    int          ren_cnt = 0;
    int          wen_cnt = 0;
    logic [31:0] last_din = 32'h0;

    always @(posedge sys_clk) begin
        if (map_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h10]   <= 32'hDEADBEEF;
            mem[8'h20]   <= 32'hAABBCCDD;
            mem[8'h30]   <= 32'h55555555;
            bus.sfr_dout <= 32'h0;
        end else if (sys_clk_en) begin
            if (bus.sfr_ren) begin
                bus.sfr_dout <= mem[bus.sfr_addr];
                ren_cnt      <= ren_cnt + 1;
            end
            if (bus.sfr_wen) begin
                mem[bus.sfr_addr] <= bus.sfr_din;
                wen_cnt           <= wen_cnt + 1;
                last_din          <= bus.sfr_din;
            end
        end
    end

    assign bus.sfr_rdonly = (bus.sfr_addr == 8'h30);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per response handshake.
    always begin
        exp_t e;
        @(negedge sys_clk);
        #1;
        if (!sys_rst && bus.rsp_valid && bus.rsp_ready && sys_clk_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata=0x%08h err=%0b, required no response",
                         bus.rsp_rdata, bus.rsp_err);
            end else begin
                e = exp_q.pop_front();
                $display("rsp: rdata=0x%08h err=%0b (expect 0x%08h err=%0b)",
                         bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
                check("rsp_rdata", bus.rsp_rdata, e.rdata);
                check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e.err});
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic issue(input logic we, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        int n = 0;
        $display("req: we=%0b addr=0x%02h wdata=0x%08h wstrb=0x%01h", we, addr, wdata, wstrb);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = wstrb;
        while (!(bus.req_ready && sys_clk_en) && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=%0b, required 1", bus.req_ready);
        end
        @(negedge sys_clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(negedge sys_clk);
            n++;
        end
        check("rsp_drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int w0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 8'h0;
        bus.req_wdata = 32'h0;
        bus.req_wstrb = 4'h0;
        bus.rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge sys_clk);
        check("rst_req_ready", {31'b0, bus.req_ready}, 0);
        check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_rsp_err", {31'b0, bus.rsp_err}, 0);
        check("rst_sfr_addr", {24'b0, bus.sfr_addr}, 0);
        check("rst_sfr_ren", {31'b0, bus.sfr_ren}, 0);
        check("rst_sfr_wen", {31'b0, bus.sfr_wen}, 0);
        check("rst_sfr_din", bus.sfr_din, 0);
        map_init = 1'b0;
        sys_rst  = 1'b0;
        #1;
        check("post_rst_req_ready", {31'b0, bus.req_ready}, 1);
        @(negedge sys_clk);

        // Read, latency 1
        exp_q.push_back('{32'hDEADBEEF, 1'b0});
        r0 = ren_cnt;
        issue(1'b0, 8'h10, 32'h0, 4'h0);
        check("rd_ren_c0", {31'b0, bus.sfr_ren}, 1);
        check("rd_addr", {24'b0, bus.sfr_addr}, 32'h10);
        check("rd_valid_c0", {31'b0, bus.rsp_valid}, 0);
        check("rd_ready_c0", {31'b0, bus.req_ready}, 0);
        @(negedge sys_clk);
        check("rd_ren_c1", {31'b0, bus.sfr_ren}, 0);
        check("rd_valid_c1", {31'b0, bus.rsp_valid}, 0);
        @(negedge sys_clk);
        check("rd_valid_c2", {31'b0, bus.rsp_valid}, 1);
        drain(10);
        check("rd_ren_pulses", ren_cnt - r0, 1);

        // Full write
        exp_q.push_back('{32'h0, 1'b0});
        r0 = ren_cnt;
        w0 = wen_cnt;
        issue(1'b1, 8'h04, 32'h12345678, 4'hF);
        check("wr_wen_c0", {31'b0, bus.sfr_wen}, 1);
        check("wr_din_c0", bus.sfr_din, 32'h12345678);
        check("wr_ren_c0", {31'b0, bus.sfr_ren}, 0);
        @(negedge sys_clk);
        check("wr_wen_c1", {31'b0, bus.sfr_wen}, 0);
        check("wr_valid_c1", {31'b0, bus.rsp_valid}, 1);
        drain(10);
        check("wr_wen_pulses", wen_cnt - w0, 1);
        check("wr_ren_pulses", ren_cnt - r0, 0);
        check("wr_mem", mem[8'h04], 32'h12345678);

`ifdef SFR_BUS_RMW_EN
        // Read-modify-write with strobe 0x5
        exp_q.push_back('{32'h0, 1'b0});
        r0 = ren_cnt;
        w0 = wen_cnt;
        issue(1'b1, 8'h20, 32'h11223344, 4'h5);
        check("rmw_ren_c0", {31'b0, bus.sfr_ren}, 1);
        check("rmw_wen_c0", {31'b0, bus.sfr_wen}, 0);
        @(negedge sys_clk);
        check("rmw_valid_c1", {31'b0, bus.rsp_valid}, 0);
        @(negedge sys_clk);
        check("rmw_wen_c2", {31'b0, bus.sfr_wen}, 1);
        check("rmw_din_c2", bus.sfr_din, 32'hAA22CC44);
        check("rmw_valid_c2", {31'b0, bus.rsp_valid}, 0);
        @(negedge sys_clk);
        check("rmw_valid_c3", {31'b0, bus.rsp_valid}, 1);
        drain(10);
        check("rmw_ren_pulses", ren_cnt - r0, 1);
        check("rmw_wen_pulses", wen_cnt - w0, 1);
        check("rmw_mem", mem[8'h20], 32'hAA22CC44);

        // Zero-strobe write: straight to response, no access
        exp_q.push_back('{32'h0, 1'b0});
        r0 = ren_cnt;
        w0 = wen_cnt;
        issue(1'b1, 8'h24, 32'hFFFFFFFF, 4'h0);
        check("zs_valid_c0", {31'b0, bus.rsp_valid}, 1);
        drain(10);
        check("zs_access", (ren_cnt - r0) + (wen_cnt - w0), 0);
        check("zs_mem", mem[8'h24], 32'h0);
`else
        // Partial strobe is a plain full-word write in this build
        exp_q.push_back('{32'h0, 1'b0});
        r0 = ren_cnt;
        w0 = wen_cnt;
        issue(1'b1, 8'h20, 32'h11223344, 4'h5);
        check("pw_wen_c0", {31'b0, bus.sfr_wen}, 1);
        check("pw_din_c0", bus.sfr_din, 32'h11223344);
        @(negedge sys_clk);
        check("pw_valid_c1", {31'b0, bus.rsp_valid}, 1);
        drain(10);
        check("pw_ren_pulses", ren_cnt - r0, 0);
        check("pw_mem", mem[8'h20], 32'h11223344);
`endif

        // Write to a read-only SFR
        exp_q.push_back('{32'h0, 1'b1});
        w0 = wen_cnt;
        issue(1'b1, 8'h30, 32'h99999999, 4'hF);
        check("ro_wen_c0", {31'b0, bus.sfr_wen}, 0);
        @(negedge sys_clk);
        check("ro_valid_c1", {31'b0, bus.rsp_valid}, 1);
        drain(10);
        check("ro_wen_pulses", wen_cnt - w0, 0);
        check("ro_mem", mem[8'h30], 32'h55555555);

        // Response backpressure for 5 cycles
        bus.rsp_ready = 1'b0;
        exp_q.push_back('{32'hDEADBEEF, 1'b0});
        issue(1'b0, 8'h10, 32'h0, 4'h0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'b0, bus.rsp_valid}, 1);
            check("bp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
            check("bp_req_ready", {31'b0, bus.req_ready}, 0);
            @(negedge sys_clk);
        end
        bus.rsp_ready = 1'b1;
        drain(10);

        // Clock-enable stall in RD_WAIT
        exp_q.push_back('{32'h12345678, 1'b0});
        r0 = ren_cnt;
        issue(1'b0, 8'h04, 32'h0, 4'h0);
        check("st_ren_c0", {31'b0, bus.sfr_ren}, 1);
        sys_clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            check("st_ren_hold", {31'b0, bus.sfr_ren}, 1);
            check("st_valid_hold", {31'b0, bus.rsp_valid}, 0);
        end
        sys_clk_en = 1'b1;
        @(negedge sys_clk);
        check("st_ren_after", {31'b0, bus.sfr_ren}, 0);
        check("st_valid_after1", {31'b0, bus.rsp_valid}, 0);
        @(negedge sys_clk);
        check("st_valid_after2", {31'b0, bus.rsp_valid}, 1);
        drain(10);
        check("st_ren_pulses", ren_cnt - r0, 1);

        // Reset while in WR
        w0 = wen_cnt;
        issue(1'b1, 8'h08, 32'hCAFEF00D, 4'hF);
        check("rw_wen_c0", {31'b0, bus.sfr_wen}, 1);
        #2;
        sys_rst = 1'b1;
        #1;
        check("rw_wen_async", {31'b0, bus.sfr_wen}, 0);
        check("rw_ready_in_rst", {31'b0, bus.req_ready}, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            check("rw_no_rsp", {31'b0, bus.rsp_valid}, 0);
        end
        check("rw_wen_pulses", wen_cnt - w0, 0);
        check("rw_mem_untouched", mem[8'h08], 32'h0);

        exp_q.push_back('{32'h0, 1'b0});
        issue(1'b1, 8'h08, 32'hCAFEF00D, 4'hF);
        drain(10);
        check("rw_retry_mem", mem[8'h08], 32'hCAFEF00D);
        exp_q.push_back('{32'hCAFEF00D, 1'b0});
        issue(1'b0, 8'h08, 32'h0, 4'h0);
        drain(10);

        repeat (2) @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
